// File: rtl/swap_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : swap_sched_pkg
// Description : Shared scheduler state encoding, default parameters and a
//               width helper for the reset_other hold counter.
// Revision    : 1.0 - initial release
// ============================================================================
package swap_sched_pkg;

  localparam int FADE_LOG2_DEFAULT  = 8;
  localparam int RESET_HOLD_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    FADE  = 2'd2,
    CLEAR = 2'd3
  } sched_state_e;

  // Bits needed to hold a count of 0..n. The result is never below one bit.
  function automatic int hold_cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_swap_scheduler_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : hold_timer
// Description : Count-down timer that sets the length of the reset_other
//               pulse. load_i arms it for HOLD cycles, count_i steps it down,
//               and expired_o is high on the final cycle of the hold.
// Revision    : 1.0 - initial release
// ============================================================================
module hold_timer
  import swap_sched_pkg::*;
#(
  parameter int HOLD = RESET_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int CW = hold_cnt_width(HOLD);
  // The count shows the cycles still to run after the current one, so a load
  // of HOLD-1 gives HOLD cycles. A zero HOLD is treated as a single cycle.
  localparam logic [CW-1:0] LOAD_VAL = (HOLD > 0) ? CW'(HOLD - 1) : '0;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on entry, otherwise step down while there is count left.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_swap_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_swap_scheduler
// Description : Schedules a swap between two processing pipelines. A request
//               arms the swap, the next sample boundary starts it, an optional
//               crossfade moves gain across one sample tick at a time, and the
//               outgoing pipeline is then held in reset for reset_hold cycles.
// Config      : Define SWAP_CROSSFADE_EN to enable the crossfade. Without it,
//               the swap is a hard cut on the first sample tick after arming,
//               and fade_pos stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_swap_scheduler
  import swap_sched_pkg::*;
#(
  parameter int fade_log2  = FADE_LOG2_DEFAULT,
  parameter int reset_hold = RESET_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               swap_req,
  input  logic               sample_tick,
  output logic               current_pipeline,
  output logic [fade_log2:0] fade_pos,
  output logic               swapping,
  output logic               reset_other,
  output logic               swap_done,
  output logic               swap_rejected
);

  localparam int FW = fade_log2 + 1;

  sched_state_e state_q, state_d;
  logic         cur_q, cur_d;
  logic         swapping_q, swapping_d;
  logic         rst_other_q, rst_other_d;
  logic         done_q, done_d;
  logic         rej_q, rej_d;
  logic         tmr_load, tmr_count, tmr_expired;

`ifdef SWAP_CROSSFADE_EN
  logic [FW-1:0] fade_q, fade_d;
  logic [FW-1:0] fade_inc;
  // The position is at most 2^fade_log2 - 1, so the increment never wraps.
  // When the top bit of the incremented value is set, the fade is complete.
  assign fade_inc = fade_q + FW'(1);
`endif

  // Next state and next registered outputs. Default is to hold, and the
  // done and rejected flags default to low so that they pulse for one cycle.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    swapping_d  = swapping_q;
    rst_other_d = rst_other_q;
    done_d      = 1'b0;
    rej_d       = 1'b0;
    tmr_load    = 1'b0;
    tmr_count   = 1'b0;
`ifdef SWAP_CROSSFADE_EN
    fade_d      = fade_q;
`endif

    // A request while busy is only flagged. It never touches the swap in flight.
    if (swap_req && (state_q != IDLE)) begin
      rej_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A sample_tick in the same cycle as the request is ignored. The
        // fade starts on the next tick.
        if (swap_req) begin
          state_d    = ARM;
          swapping_d = 1'b1;
        end
      end
`ifdef SWAP_CROSSFADE_EN
      ARM, FADE: begin
        if (sample_tick) begin
          if (fade_inc[fade_log2]) begin
            cur_d       = ~cur_q;
            fade_d      = '0;
            state_d     = CLEAR;
            rst_other_d = 1'b1;
            tmr_load    = 1'b1;
          end else begin
            fade_d  = fade_inc;
            state_d = FADE;
          end
        end
      end
`else
      ARM: begin
        if (sample_tick) begin
          cur_d       = ~cur_q;
          state_d     = CLEAR;
          rst_other_d = 1'b1;
          tmr_load    = 1'b1;
        end
      end
`endif
      CLEAR: begin
        // sample_tick is ignored in this state. reset_other stays high until
        // the timer reaches its final cycle.
        if (tmr_expired) begin
          state_d     = IDLE;
          rst_other_d = 1'b0;
          swapping_d  = 1'b0;
          done_d      = 1'b1;
        end else begin
          tmr_count = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        swapping_d  = 1'b0;
        rst_other_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset forces all of them low, even in the
  // middle of a swap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cur_q       <= 1'b0;
      swapping_q  <= 1'b0;
      rst_other_q <= 1'b0;
      done_q      <= 1'b0;
      rej_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      swapping_q  <= swapping_d;
      rst_other_q <= rst_other_d;
      done_q      <= done_d;
      rej_q       <= rej_d;
    end
  end

`ifdef SWAP_CROSSFADE_EN
  // Register for the crossfade position, the gain of the non-current pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fade_q <= '0;
    end else begin
      fade_q <= fade_d;
    end
  end
  assign fade_pos = fade_q;
`else
  assign fade_pos = '0;
`endif

  hold_timer #(
    .HOLD (reset_hold)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .count_i   (tmr_count),
    .expired_o (tmr_expired)
  );

  assign current_pipeline = cur_q;
  assign swapping         = swapping_q;
  assign reset_other      = rst_other_q;
  assign swap_done        = done_q;
  assign swap_rejected    = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_swap_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_swap_scheduler
// Description : Directed bench for pipeline_swap_scheduler with fade_log2=2
//               and reset_hold=4. Expectations follow SWAP_CROSSFADE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_swap_scheduler;

  localparam int FL2 = 2;
  localparam int RH  = 4;
`ifdef SWAP_CROSSFADE_EN
  localparam int TICKS = 1 << FL2;
`else
  localparam int TICKS = 1;
`endif

  typedef struct packed {
    logic       cp;
    logic [2:0] fp;
    logic       sw;
    logic       ro;
    logic       sd;
    logic       sr;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       swap_req = 1'b0;
  logic       sample_tick = 1'b0;
  logic       current_pipeline;
  logic [2:0] fade_pos;
  logic       swapping;
  logic       reset_other;
  logic       swap_done;
  logic       swap_rejected;

  int    checks = 0;
  int    failures = 0;
  obs_t  exp_q[$];
  string tag_q[$];

  pipeline_swap_scheduler #(
    .fade_log2  (FL2),
    .reset_hold (RH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .swap_req         (swap_req),
    .sample_tick      (sample_tick),
    .current_pipeline (current_pipeline),
    .fade_pos         (fade_pos),
    .swapping         (swapping),
    .reset_other      (reset_other),
    .swap_done        (swap_done),
    .swap_rejected    (swap_rejected)
  );

  always #5 clk = ~clk;

  function automatic obs_t E(input logic cp, input logic [2:0] fp, input logic sw,
                             input logic ro, input logic sd, input logic sr);
    obs_t o;
    o.cp = cp; o.fp = fp; o.sw = sw; o.ro = ro; o.sd = sd; o.sr = sr;
    return o;
  endfunction

  // Pop the oldest expectation and compare it with the outputs now present.
  task automatic compare_head();
    obs_t  e;
    obs_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {current_pipeline, fade_pos, swapping, reset_other, swap_done, swap_rejected};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed cp=%b fp=%0d sw=%b ro=%b sd=%b sr=%b expected cp=%b fp=%0d sw=%b ro=%b sd=%b sr=%b",
             t, o.cp, o.fp, o.sw, o.ro, o.sd, o.sr, e.cp, e.fp, e.sw, e.ro, e.sd, e.sr);
    end
  endtask

  task automatic check_now(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare_head();
  endtask

  // Drive one cycle of inputs, record what that edge must produce, then check
  // the outputs 1 ns after the edge.
  task automatic step(input logic req, input logic tick, input string tag, input obs_t e);
    swap_req    = req;
    sample_tick = tick;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    swap_req    = 1'b0;
    sample_tick = 1'b0;
    compare_head();
  endtask

  // A full swap from IDLE. The request comes with a tick that must be ignored,
  // ticks in CLEAR are also ignored, and the swap ends with a swap_done pulse.
  task automatic do_swap(input logic cp0);
    step(1'b1, 1'b1, "arm_same_cycle_tick", E(cp0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b0, "arm_hold",            E(cp0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k < TICKS; k++) begin
      step(1'b0, 1'b1, "fade_inc",  E(cp0, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0));
      step(1'b0, 1'b0, "fade_hold", E(cp0, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, 1'b1, "toggle", E(~cp0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    for (int h = 2; h <= RH; h++) begin
      step(1'b0, 1'b1, "clear_tick_ignored", E(~cp0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    end
    step(1'b0, 1'b0, "swap_done", E(~cp0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
  endtask

  initial begin
    // Reset asserted from time zero
    #2;
    check_now("reset_state", E(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_now("idle_after_reset", E(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Swap 0->1, then a back-to-back swap 1->0 the cycle after swap_done
    do_swap(1'b0);
    do_swap(1'b1);
    step(1'b0, 1'b0, "idle_after_b2b", E(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Swap 0->1 interrupted by reset on the second reset_other cycle
    step(1'b1, 1'b0, "arm3", E(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k < TICKS; k++) begin
      step(1'b0, 1'b1, "fade3_inc", E(1'b0, 3'(k), 1'b1, 1'b0, 1'b0, 1'b0));
    end
    step(1'b0, 1'b1, "toggle3",   E(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b0, "clear3_c2", E(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    #1;
    reset = 1'b0;
    #1;
    check_now("reset_async_mid_clear", E(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check_now("reset_held", E(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    #1;
    check_now("released_idle", E(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Request on the first edge after release, then busy requests
    step(1'b1, 1'b0, "first_edge_req", E(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, "busy_in_arm",    E(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, "reject_clears",  E(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef SWAP_CROSSFADE_EN
    step(1'b0, 1'b1, "fade4_1",      E(1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, "fade4_2",      E(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b1, 1'b0, "busy_in_fade", E(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, "fade4_hold",   E(1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, "fade4_3",      E(1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
    step(1'b0, 1'b1, "toggle4",       E(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b1, 1'b0, "busy_in_clear", E(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    step(1'b0, 1'b0, "clear4_c3",     E(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b0, "clear4_c4",     E(1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b0, "swap_done4",    E(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    step(1'b0, 1'b1, "idle_tick",     E(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
